// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request/response port among NUM_REQS
// requesters. The winning request is registered and held until the memory side
// accepts it. The requester index is appended to the outgoing tag so that read
// responses can be routed back combinationally. Per-requester pending-read
// counters cap how many reads each requester may have outstanding.
module mem_req_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 26,
  parameter int TAG_IN_WIDTH = 6,
  parameter int MAX_PENDING  = 8,
  localparam int LOG_REQS      = $clog2(NUM_REQS),
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_REQS,
  localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8,
  localparam int CNT_WIDTH     = $clog2(MAX_PENDING + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQS-1:0]                 req_valid,
  input  logic [NUM_REQS-1:0]                 req_rw,
  input  logic [NUM_REQS*BYTEEN_WIDTH-1:0]    req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]      req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]      req_data,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]    req_tag,
  output logic [NUM_REQS-1:0]                 req_ready,
  output logic [NUM_REQS-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_data,
  output logic [TAG_IN_WIDTH-1:0]             rsp_tag,
  input  logic [NUM_REQS-1:0]                 rsp_ready,
  output logic                                mem_req_valid,
  output logic                                mem_req_rw,
  output logic [BYTEEN_WIDTH-1:0]             mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]               mem_req_addr,
  output logic [DATA_WIDTH-1:0]               mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]            mem_req_tag,
  input  logic                                mem_req_ready,
  input  logic                                mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]               mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]            mem_rsp_tag,
  output logic                                mem_rsp_ready
);

  if (NUM_REQS < 2) begin : g_bad_num_reqs
    $error("mem_req_arbiter: NUM_REQS must be >= 2");
  end
  if (MAX_PENDING < 1) begin : g_bad_max_pending
    $error("mem_req_arbiter: MAX_PENDING must be >= 1");
  end

  logic [CNT_WIDTH-1:0]     pend_q [NUM_REQS];
  logic [LOG_REQS-1:0]      ptr_q;
  logic [NUM_REQS-1:0]      elig;
  logic [NUM_REQS-1:0]      grant_oh;
  logic [LOG_REQS-1:0]      grant_idx;
  logic [LOG_REQS-1:0]      cand;
  logic                     grant_hit;
  logic                     grant_vld;
  logic                     slot_free;
  logic [NUM_REQS-1:0]      pend_inc;
  logic [NUM_REQS-1:0]      pend_dec;
  logic [LOG_REQS-1:0]      rsp_idx;
  logic                     rsp_idx_ok;
  logic                     rsp_fire;

  logic                     vld_p1;
  logic                     rw_p1;
  logic [BYTEEN_WIDTH-1:0]  byteen_p1;
  logic [ADDR_WIDTH-1:0]    addr_p1;
  logic [DATA_WIDTH-1:0]    data_p1;
  logic [TAG_OUT_WIDTH-1:0] tag_p1;

  // Eligibility: writes always pass, reads only below the pending cap
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      elig[i] = req_valid[i] && (req_rw[i] || (pend_q[i] < CNT_WIDTH'(MAX_PENDING)));
    end
  end

  // Round-robin search starting just after the last granted index
  always_comb begin
    grant_idx = '0;
    grant_hit = 1'b0;
    cand      = '0;
    slot_free = !vld_p1 || mem_req_ready;
    for (int k = 1; k <= NUM_REQS; k++) begin
      cand = LOG_REQS'((int'(ptr_q) + k) % NUM_REQS);
      if (!grant_hit && elig[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
    end
    grant_vld = grant_hit && slot_free && !reset;
    grant_oh  = grant_vld ? (NUM_REQS'(1) << grant_idx) : '0;
    req_ready = grant_oh;
  end

  // Response routing back to the requester named in the low tag bits
  always_comb begin
    rsp_idx    = mem_rsp_tag[LOG_REQS-1:0];
    rsp_idx_ok = (int'(rsp_idx) < NUM_REQS);
    rsp_valid  = '0;
    if (!reset && rsp_idx_ok) begin
      rsp_valid[rsp_idx] = mem_rsp_valid;
    end
    mem_rsp_ready = !reset && rsp_idx_ok && rsp_ready[rsp_idx];
    rsp_tag       = mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_REQS];
    rsp_data      = mem_rsp_data;
    rsp_fire      = mem_rsp_valid && mem_rsp_ready;
  end

  // Per-requester counter events: read grants and response handshakes
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      pend_inc[i] = grant_oh[i] && !req_rw[i];
      pend_dec[i] = rsp_fire && (rsp_idx == LOG_REQS'(i));
    end
  end

  // Round-robin pointer remembers the most recent winner
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= LOG_REQS'(NUM_REQS - 1);
    end else if (grant_vld) begin
      ptr_q <= grant_idx;
    end
  end

  // Stage p1: registered request, frozen while the memory side stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      rw_p1     <= 1'b0;
      byteen_p1 <= '0;
      addr_p1   <= '0;
      data_p1   <= '0;
      tag_p1    <= '0;
    end else if (grant_vld) begin
      vld_p1    <= 1'b1;
      rw_p1     <= req_rw[grant_idx];
      byteen_p1 <= req_byteen[grant_idx*BYTEEN_WIDTH +: BYTEEN_WIDTH];
      addr_p1   <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      data_p1   <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      tag_p1    <= {req_tag[grant_idx*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx};
    end else if (vld_p1 && mem_req_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  // Pending-read counters; simultaneous increment and decrement cancel
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (reset) begin
        pend_q[i] <= '0;
      end else if (pend_inc[i] && !pend_dec[i]) begin
        pend_q[i] <= pend_q[i] + CNT_WIDTH'(1);
      end else if (!pend_inc[i] && pend_dec[i] && (pend_q[i] != '0)) begin
        pend_q[i] <= pend_q[i] - CNT_WIDTH'(1);
      end
    end
  end

`ifndef SYNTHESIS
  // Runtime sanity: responses must name a real requester and never underflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (mem_rsp_valid) begin
        assert (rsp_idx_ok) else $error("mem_req_arbiter: response index out of range");
      end
      for (int i = 0; i < NUM_REQS; i++) begin
        if (pend_dec[i] && !pend_inc[i]) begin
          assert (pend_q[i] != '0) else $error("mem_req_arbiter: pending counter underflow");
        end
      end
    end
  end
`endif

  assign mem_req_valid  = vld_p1;
  assign mem_req_rw     = rw_p1;
  assign mem_req_byteen = byteen_p1;
  assign mem_req_addr   = addr_p1;
  assign mem_req_data   = data_p1;
  assign mem_req_tag    = tag_p1;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: 4 requesters, small widths, MAX_PENDING=2.
module tb_mem_req_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int TW  = 6;
  localparam int MP  = 2;
  localparam int BW  = DW / 8;
  localparam int TOW = TW + 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_rw;
  logic [NR*BW-1:0] req_byteen;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR*TW-1:0] req_tag;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic [TW-1:0]    rsp_tag;
  logic [NR-1:0]    rsp_ready;
  logic             mem_req_valid;
  logic             mem_req_rw;
  logic [BW-1:0]    mem_req_byteen;
  logic [AW-1:0]    mem_req_addr;
  logic [DW-1:0]    mem_req_data;
  logic [TOW-1:0]   mem_req_tag;
  logic             mem_req_ready;
  logic             mem_rsp_valid;
  logic [DW-1:0]    mem_rsp_data;
  logic [TOW-1:0]   mem_rsp_tag;
  logic             mem_rsp_ready;

  int errors;
  int checks;

  mem_req_arbiter #(
    .NUM_REQS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_byteen(req_byteen),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic rw, input logic [AW-1:0] a,
                         input logic [TW-1:0] t, input logic [DW-1:0] d, input logic [BW-1:0] be);
    req_valid[i]           = v;
    req_rw[i]              = rw;
    req_addr[i*AW +: AW]   = a;
    req_tag[i*TW +: TW]    = t;
    req_data[i*DW +: DW]   = d;
    req_byteen[i*BW +: BW] = be;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 8'h00, 6'h00, 32'h0, 4'hF);
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {6'h01, 2'd0};
    rsp_ready     = 4'hF;
    step();
    step();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (mem_rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_rsp_ready got=%b exp=0", mem_rsp_ready); end
    checks++; if (mem_req_tag !== 8'h00) begin errors++; $display("FAIL reset_payload_tag got=%h exp=00", mem_req_tag); end
    checks++; if (dut.pend_q[0] !== 2'd0) begin errors++; $display("FAIL reset_pend0 got=%0d exp=0", dut.pend_q[0]); end
    mem_rsp_valid = 1'b0;
    req_valid     = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    logic [7:0] exp_tag;
    int j;
    for (int i = 0; i < NR; i++)
      set_req(i, 1'b1, 1'b0, 8'(8'h40 + i), 6'(16 + i), 32'hA000_0000 + 32'(i), 4'hF);
    mem_req_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_oh = 4'(1 << (k % 4));
      checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, exp_oh); end
      if (k == 0) begin
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rr_first_latency got=%b exp=0", mem_req_valid); end
      end else begin
        j = (k - 1) % 4;
        exp_tag = {6'(16 + j), 2'(j)};
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rr_mem_valid k=%0d got=%b exp=1", k, mem_req_valid); end
        checks++; if (mem_req_tag !== exp_tag) begin errors++; $display("FAIL rr_mem_tag k=%0d got=%h exp=%h", k, mem_req_tag, exp_tag); end
        checks++; if (mem_req_addr !== 8'(8'h40 + j)) begin errors++; $display("FAIL rr_mem_addr k=%0d got=%h exp=%h", k, mem_req_addr, 8'(8'h40 + j)); end
      end
      step();
    end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_cap_stall got=%b exp=0000", req_ready); end
    checks++; if (mem_req_tag[1:0] !== 2'd3) begin errors++; $display("FAIL rr_last_tag got=%0d exp=3", mem_req_tag[1:0]); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (dut.pend_q[i] !== 2'd2) begin errors++; $display("FAIL rr_pend%0d got=%0d exp=2", i, dut.pend_q[i]); end
    end
    req_valid = '0;
    step();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rr_drain_valid got=%b exp=0", mem_req_valid); end
    for (int i = 0; i < NR; i++) begin
      for (int r = 0; r < 2; r++) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = {6'(5 + i), 2'(i)};
        mem_rsp_data  = 32'hD000_0000 + 32'(i);
        rsp_ready     = 4'hF;
        #1;
        exp_oh = 4'(1 << i);
        checks++; if (rsp_valid !== exp_oh) begin errors++; $display("FAIL rr_rsp_valid i=%0d got=%b exp=%b", i, rsp_valid, exp_oh); end
        checks++; if (rsp_tag !== 6'(5 + i)) begin errors++; $display("FAIL rr_rsp_tag i=%0d got=%h exp=%h", i, rsp_tag, 6'(5 + i)); end
        checks++; if (rsp_data !== 32'hD000_0000 + 32'(i)) begin errors++; $display("FAIL rr_rsp_data i=%0d got=%h", i, rsp_data); end
        step();
      end
    end
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < NR; i++) begin
      checks++; if (dut.pend_q[i] !== 2'd0) begin errors++; $display("FAIL rr_pend_drained%0d got=%0d exp=0", i, dut.pend_q[i]); end
    end
  endtask

  task automatic test_hold();
    mem_req_ready = 1'b0;
    set_req(2, 1'b1, 1'b1, 8'hA2, 6'h22, 32'hCAFE_0002, 4'hA);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL hold_grant got=%b exp=0100", req_ready); end
    step();
    set_req(2, 1'b1, 1'b1, 8'hB2, 6'h23, 32'hBEEF_0002, 4'h5);
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL hold_valid c=%0d got=%b exp=1", c, mem_req_valid); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_no_grant c=%0d got=%b exp=0000", c, req_ready); end
      checks++;
      if ({mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag} !== {1'b1, 4'hA, 8'hA2, 32'hCAFE_0002, 6'h22, 2'd2}) begin
        errors++;
        $display("FAIL hold_payload c=%0d got=%b %h %h %h %h exp=1 a a2 cafe0002 8a", c, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag);
      end
      step();
    end
    mem_req_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL hold_fire_regrant got=%b exp=0100", req_ready); end
    step();
    req_valid[2] = 1'b0;
    #1;
    checks++; if (mem_req_addr !== 8'hB2) begin errors++; $display("FAIL hold_next_addr got=%h exp=b2", mem_req_addr); end
    checks++; if (mem_req_tag !== {6'h23, 2'd2}) begin errors++; $display("FAIL hold_next_tag got=%h exp=8e", mem_req_tag); end
    step();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL hold_idle got=%b exp=0", mem_req_valid); end
  endtask

  task automatic test_pending();
    logic [1:0] idxs [3];
    idxs[0] = 2'd1; idxs[1] = 2'd1; idxs[2] = 2'd0;
    mem_req_ready = 1'b1;
    set_req(1, 1'b1, 1'b0, 8'h51, 6'h31, 32'h0000_0051, 4'hF);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL pend_read1 got=%b exp=0010", req_ready); end
    step();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL pend_read2 got=%b exp=0010", req_ready); end
    step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL pend_read3_stall got=%b exp=0000", req_ready); end
    checks++; if (dut.pend_q[1] !== 2'd2) begin errors++; $display("FAIL pend_cnt_full got=%0d exp=2", dut.pend_q[1]); end
    req_rw[1] = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL pend_write_pass got=%b exp=0010", req_ready); end
    step();
    req_rw[1] = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h50, 6'h30, 32'h0000_0050, 4'hF);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL pend_other_read got=%b exp=0001", req_ready); end
    checks++; if ({mem_req_rw, mem_req_tag[1:0]} !== 3'b101) begin errors++; $display("FAIL pend_write_out got=%b exp=101", {mem_req_rw, mem_req_tag[1:0]}); end
    step();
    req_valid[0] = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL pend_still_stall got=%b exp=0000", req_ready); end
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {6'h31, 2'd1};
    rsp_ready     = 4'b0010;
    #1;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL pend_rsp_valid got=%b exp=0010", rsp_valid); end
    checks++; if (mem_rsp_ready !== 1'b1) begin errors++; $display("FAIL pend_rsp_ready got=%b exp=1", mem_rsp_ready); end
    step();
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL pend_release got=%b exp=0010", req_ready); end
    step();
    req_valid[1] = 1'b0;
    #1;
    checks++; if (dut.pend_q[1] !== 2'd2) begin errors++; $display("FAIL pend_cnt1 got=%0d exp=2", dut.pend_q[1]); end
    checks++; if (dut.pend_q[0] !== 2'd1) begin errors++; $display("FAIL pend_cnt0 got=%0d exp=1", dut.pend_q[0]); end
    for (int r = 0; r < 3; r++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = {6'h31, idxs[r]};
      rsp_ready     = 4'hF;
      #1;
      step();
    end
    mem_rsp_valid = 1'b0;
    checks++; if ({dut.pend_q[1], dut.pend_q[0]} !== 4'b0000) begin errors++; $display("FAIL pend_drained got=%b exp=0000", {dut.pend_q[1], dut.pend_q[0]}); end
  endtask

  task automatic test_rsp_routing();
    mem_req_ready = 1'b1;
    set_req(3, 1'b1, 1'b0, 8'h53, 6'h2A, 32'h0000_0053, 4'hF);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL route_grant3 got=%b exp=1000", req_ready); end
    step();
    req_valid[3] = 1'b0;
    #1;
    checks++; if (dut.pend_q[3] !== 2'd1) begin errors++; $display("FAIL route_pend_up got=%0d exp=1", dut.pend_q[3]); end
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {6'h2A, 2'd3};
    mem_rsp_data  = 32'h1234_5678;
    rsp_ready     = 4'b0111;
    #1;
    checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL route_rsp_valid got=%b exp=1000", rsp_valid); end
    checks++; if (rsp_tag !== 6'h2A) begin errors++; $display("FAIL route_rsp_tag got=%h exp=2a", rsp_tag); end
    checks++; if (rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL route_rsp_data got=%h exp=12345678", rsp_data); end
    checks++; if (mem_rsp_ready !== 1'b0) begin errors++; $display("FAIL route_backpressure got=%b exp=0", mem_rsp_ready); end
    step();
    checks++; if (dut.pend_q[3] !== 2'd1) begin errors++; $display("FAIL route_pend_hold got=%0d exp=1", dut.pend_q[3]); end
    rsp_ready = 4'hF;
    #1;
    checks++; if (mem_rsp_ready !== 1'b1) begin errors++; $display("FAIL route_ready_up got=%b exp=1", mem_rsp_ready); end
    step();
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (dut.pend_q[3] !== 2'd0) begin errors++; $display("FAIL route_pend_down got=%0d exp=0", dut.pend_q[3]); end
  endtask

  task automatic test_same_cycle();
    mem_req_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 8'h70, 6'h07, 32'h0000_0070, 4'hF);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL same_first_grant got=%b exp=0001", req_ready); end
    step();
    checks++; if (dut.pend_q[0] !== 2'd1) begin errors++; $display("FAIL same_pend_one got=%0d exp=1", dut.pend_q[0]); end
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {6'h07, 2'd0};
    rsp_ready     = 4'hF;
    #1;
    checks++; if ({req_ready, mem_rsp_ready} !== 5'b0001_1) begin errors++; $display("FAIL same_both_fire got=%b exp=00011", {req_ready, mem_rsp_ready}); end
    step();
    req_valid[0]  = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (dut.pend_q[0] !== 2'd1) begin errors++; $display("FAIL same_pend_unchanged got=%0d exp=1", dut.pend_q[0]); end
    mem_rsp_valid = 1'b1;
    #1;
    step();
    mem_rsp_valid = 1'b0;
    checks++; if (dut.pend_q[0] !== 2'd0) begin errors++; $display("FAIL same_pend_drained got=%0d exp=0", dut.pend_q[0]); end
  endtask

  task automatic test_reset_mid();
    mem_req_ready = 1'b0;
    set_req(1, 1'b1, 1'b0, 8'h61, 6'h11, 32'h0000_0061, 4'hF);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_grant got=%b exp=0010", req_ready); end
    step();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 8'(8'h80 + i), 6'(32 + i), 32'h0000_0080, 4'hF);
    #1;
    checks++; if ({mem_req_valid, dut.pend_q[1]} !== 3'b1_01) begin errors++; $display("FAIL rmid_pre got=%b exp=101", {mem_req_valid, dut.pend_q[1]}); end
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rmid_in_reset got=%b exp=0000", req_ready); end
    step();
    reset         = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_dropped got=%b exp=0", mem_req_valid); end
    checks++; if (mem_req_addr !== 8'h00) begin errors++; $display("FAIL rmid_payload got=%h exp=00", mem_req_addr); end
    checks++; if (dut.pend_q[1] !== 2'd0) begin errors++; $display("FAIL rmid_pend_clear got=%0d exp=0", dut.pend_q[1]); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_first_grant got=%b exp=0001", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if (mem_req_tag !== {6'h20, 2'd0}) begin errors++; $display("FAIL rmid_out_tag got=%h exp=80", mem_req_tag); end
    step();
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    req_valid     = '0;
    req_rw        = '0;
    req_byteen    = '0;
    req_addr      = '0;
    req_data      = '0;
    req_tag       = '0;
    rsp_ready     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_tag   = '0;
    test_reset();
    test_round_robin();
    test_hold();
    test_pending();
    test_rsp_routing();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
